rr_grant_sequencer8: RTL
========================

// Module: rr_grant_sequencer8
// PURPOSE
//  - Round-robin arbiter and sequencer that shares one 8-way select resource
//    between 8 requesters.
//  - Picks one requester, holds the grant until release or timeout, then
//    rotates priority.
//  - The grant is driven as a 3-bit index plus its one-hot 3-to-8 decode.
//  - Sits in front of the decoder/select datapath: the index feeds the
//    decoder, the one-hot drives the per-requester enables.
// PARAMETERS
//  MAX_HOLD  16  max consecutive grant cycles per owner; 0 = no timeout
//  CNT_W     5   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous reset, active-high
//  req        in   8  request vector, bit i = requester i (level, held while wanted)
//  gnt        out  8  one-hot grant, registered; all-zero when no owner
//  gnt_idx    out  3  binary index of owner; valid only when gnt_valid=1
//  gnt_valid  out  1  registered; 1 while a grant is active
//  timeout    out  1  1-cycle pulse on the cycle the grant is force-released
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - state=IDLE; gnt=0; gnt_idx=0; gnt_valid=0; timeout=0; ptr=0; hold_cnt=0.
//   - Reset mid-grant drops the grant at that edge, with no timeout pulse.
//  State machine
//   - States: IDLE, GRANT.
//  IDLE
//   - If req!=0, select the first set bit scanning ptr, ptr+1, ... wrapping mod 8.
//   - At the next edge: state=GRANT, gnt_idx=sel, gnt=1<<sel, gnt_valid=1,
//     hold_cnt=0.
//   - Latency is 1 cycle from req sampled high to gnt visible.
//   - If req==0, stay in IDLE with outputs 0.
//  GRANT
//   - Each cycle, hold_cnt increments.
//   - Release when req[gnt_idx]==0 OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
//   - On release, at the next edge: state=IDLE, gnt=0, gnt_valid=0,
//     ptr=(gnt_idx+1) mod 8 (3-bit wrap, 7 -> 0).
//   - timeout=1 for that one cycle only when the release was the hold limit
//     AND req[gnt_idx] was still 1.
//   - If the requester drops on exactly the limit cycle, this is a normal
//     release with timeout=0.
//   - Changes to other req bits during GRANT are ignored; they do not preempt.
//  Handover
//   - Each release passes through exactly one IDLE cycle (1-cycle bubble),
//     then the next arbitration happens.
//   - A timed-out owner that still requests competes again from its new
//     rotated position. It is re-granted only if no other bit is set.
//  Invariants
//   - gnt is always zero or one-hot.
//   - gnt == (gnt_valid ? 8'b1<<gnt_idx : 8'b0).
//   - gnt_idx holds its last value while gnt_valid=0.
//  Width/arith
//   - ptr and gnt_idx are 3-bit and wrap naturally.
//   - hold_cnt is CNT_W bits and never exceeds MAX_HOLD-1.
// TESTING
//  1. Reset: rst=1 with req=8'hFF.
//     -> gnt=0, gnt_valid=0, timeout=0.
//     After rst drops: gnt=8'h01 one cycle later.
//  2. Rotation: req=8'hFF held, MAX_HOLD=0, owner drops its req bit for 1 cycle
//     after each grant.
//     -> grants go 01,02,04,...,80,01 with a 1-cycle bubble between each.
//  3. Single requester: req=8'h20 for 5 cycles, then 0.
//     -> gnt=8'h20 and gnt_idx=5 for 5 cycles, then 0.
//     ptr=6, so a next req=8'h61 grants 8'h40.
//  4. Timeout: MAX_HOLD=4, req=8'h09 held.
//     -> gnt=8'h01 for 4 cycles, timeout pulse, bubble, gnt=8'h08.
//     Then 4 cycles, timeout, bubble, gnt=8'h01.
//  5. Limit tie: MAX_HOLD=4, owner drops req on its 4th grant cycle.
//     -> release with timeout=0.
//  6. Mid-grant reset: rst pulsed while gnt=8'h10.
//     -> gnt=0 at that edge, ptr=0; a following req=8'h11 grants 8'h01.

Source files
------------

// File: rtl/rr_grant_sequencer8.sv
// rr_grant_sequencer8
//   Round-robin arbiter that lets 8 requesters share one 8-way select
//   resource. It picks one owner, holds the grant until the owner drops its
//   request or the hold limit expires, then rotates priority past that owner.
//   Every release is followed by one idle bubble cycle before re-arbitration.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req[7:0]   level requests, bit i = requester i
//   gnt[7:0]   registered one-hot grant, zero when there is no owner
//   gnt_idx    binary owner index; holds its last value while idle
//   gnt_valid  high while a grant is active
//   timeout    one-cycle pulse on the cycle a grant is force-released
module rr_grant_sequencer8 #(
  parameter int MAX_HOLD = 16,  // max grant cycles per owner, 0 = unlimited
  parameter int CNT_W    = 5    // 2**CNT_W must exceed MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);
  localparam logic             HAS_LIMIT = (MAX_HOLD != 0);

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             to_q, to_d;

  // First set request scanning ptr, ptr+1, ... with natural 3-bit wrap.
  logic       found;
  logic [2:0] sel;
  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!found && req[ptr_q + 3'(i)]) begin
        found = 1'b1;
        sel   = ptr_q + 3'(i);
      end
    end
  end

  logic owner_req, at_limit;
  assign owner_req = req[idx_q];
  assign at_limit  = HAS_LIMIT && (hold_q == LIMIT);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = 8'h00;
        if (found) begin
          state_d = GRANT;
          idx_d   = sel;
          gnt_d   = 8'h01 << sel;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!owner_req || at_limit) begin
          state_d = IDLE;
          gnt_d   = 8'h00;
          ptr_d   = idx_q + 3'd1;
          hold_d  = '0;
          // A requester that drops on the limit cycle is a normal release.
          to_d    = at_limit && owner_req;
        end else if (HAS_LIMIT) begin
          hold_d  = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      hold_q  <= '0;
      gnt_q   <= 8'h00;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = to_q;

endmodule
